stream_demux_1_4: RTL and testbench

STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

---
 rtl/stream_demux_1_4_if.sv | 54 +++++
 rtl/stream_demux_1_4.sv | 75 +++++++
 tb/tb_stream_demux_1_4.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1_4_if.sv
// Stream demux 1-to-4 handshake bundle.
// One upstream port, four downstream channels.
interface stream_demux_1_4_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0;
  logic [W-1:0] out_data1;
  logic [W-1:0] out_data2;
  logic [W-1:0] out_data3;
  logic [7:0]   beat_cnt0;
  logic [7:0]   beat_cnt1;
  logic [7:0]   beat_cnt2;
  logic [7:0]   beat_cnt3;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_sel,
    input  out_valid,
    output out_ready,
    input  out_data0,
    input  out_data1,
    input  out_data2,
    input  out_data3,
    input  beat_cnt0,
    input  beat_cnt1,
    input  beat_cnt2,
    input  beat_cnt3
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_sel,
    output out_valid,
    input  out_ready,
    output out_data0,
    output out_data1,
    output out_data2,
    output out_data3,
    output beat_cnt0,
    output beat_cnt1,
    output beat_cnt2,
    output beat_cnt3
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// Stream demux 1-to-4 with a one-entry holding
// register and a beat counter per channel.
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  stream_demux_1_4_if.slave bus
);

  logic [3:0]   full_q;
  logic [3:0]   full_d;
  logic [W-1:0] data_q [4];
  logic [W-1:0] data_d [4];
  logic [7:0]   cnt_q  [4];
  logic [7:0]   cnt_d  [4];
  logic [3:0]   sel_oh;
  logic [3:0]   load;
  logic [3:0]   drain;
  logic         rdy;

  // Accept when the target slot is free or
  // drains on this same edge; never in reset.
  always_comb begin
    sel_oh = 4'b0001 << bus.in_sel;
    rdy    = !rst &&
             (!full_q[bus.in_sel] ||
              bus.out_ready[bus.in_sel]);
    load   = (bus.in_valid && rdy) ? sel_oh
                                   : 4'b0000;
    drain  = full_q & bus.out_ready;
  end

  // Per-channel next state: a load wins over a
  // drain, so drain+load keeps the slot full.
  always_comb begin
    full_d = (full_q & ~drain) | load;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = load[k] ? bus.in_data
                          : data_q[k];
      cnt_d[k]  = cnt_q[k] +
                  {7'd0, drain[k]};
    end
  end

  // State update; reset discards held beats
  // without counting them.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= 8'd0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = full_q;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
  assign bus.beat_cnt0 = cnt_q[0];
  assign bus.beat_cnt1 = cnt_q[1];
  assign bus.beat_cnt2 = cnt_q[2];
  assign bus.beat_cnt3 = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Scoreboard bench for stream_demux_1_4:
// directed scenarios then random traffic.
module tb_stream_demux_1_4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  stream_demux_1_4_if #(.W(W)) bus ();

  stream_demux_1_4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] od [4];
  logic [7:0]   bc [4];
  assign od[0] = bus.out_data0;
  assign od[1] = bus.out_data1;
  assign od[2] = bus.out_data2;
  assign od[3] = bus.out_data3;
  assign bc[0] = bus.beat_cnt0;
  assign bc[1] = bus.beat_cnt1;
  assign bc[2] = bus.beat_cnt2;
  assign bc[3] = bus.beat_cnt3;

  // Reference model: one FIFO per channel
  // (capacity 1), last loaded value, and the
  // number of beats delivered since reset.
  logic [W-1:0] q [4][$];
  logic [W-1:0] last_v [4];
  int           deliv [4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  // Monitor: compare outputs to the model on
  // the falling edge, then advance the model
  // by what the coming rising edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      logic         er;
      logic [1:0]   s;
      logic [W-1:0] got;
      s  = bus.in_sel;
      er = !rst &&
           (q[s].size() == 0 || bus.out_ready[s]);
      chk("in_ready", {31'd0, bus.in_ready},
          {31'd0, er});
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid%0d", k),
            {31'd0, bus.out_valid[k]},
            {31'd0, q[k].size() != 0});
        chk($sformatf("out_data%0d", k),
            {{(32-W){1'b0}}, od[k]},
            {{(32-W){1'b0}}, last_v[k]});
        chk($sformatf("beat_cnt%0d", k),
            {24'd0, bc[k]},
            {24'd0, deliv[k][7:0]});
      end
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          q[k].delete();
          last_v[k] = '0;
          deliv[k]  = 0;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (q[k].size() != 0 &&
              bus.out_ready[k]) begin
            got = q[k].pop_front();
            chk($sformatf("deliver%0d", k),
                {{(32-W){1'b0}}, od[k]},
                {{(32-W){1'b0}}, got});
            deliv[k]++;
          end
        end
        if (bus.in_valid && er) begin
          q[s].push_back(bus.in_data);
          last_v[s] = bus.in_data;
        end
      end
    end
  end

  task automatic cyc(input logic v,
                     input logic [1:0] s,
                     input logic [W-1:0] d,
                     input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      last_v[k] = '0;
      deliv[k]  = 0;
    end
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(1'b1, 2'd1, 4'h7, 4'b0000);
    rst = 1'b0;

    // Four beats, one per channel.
    cyc(1'b1, 2'd0, 4'hA, 4'b1111);
    cyc(1'b1, 2'd1, 4'hB, 4'b1111);
    cyc(1'b1, 2'd2, 4'hC, 4'b1111);
    cyc(1'b1, 2'd3, 4'hD, 4'b1111);
    cyc(1'b0, 2'd0, 4'h0, 4'b1111);
    cyc(1'b0, 2'd0, 4'h0, 4'b1111);

    // Stalled channel 2, bypass via channel 1,
    // then drain+load on the same edge.
    cyc(1'b1, 2'd2, 4'hC, 4'b1011);
    cyc(1'b1, 2'd2, 4'h5, 4'b1011);
    cyc(1'b1, 2'd1, 4'h9, 4'b1011);
    cyc(1'b1, 2'd2, 4'h5, 4'b1111);
    cyc(1'b0, 2'd0, 4'h0, 4'b1111);

    // Channel 3 full, then streamed 10 beats.
    cyc(1'b1, 2'd3, 4'hE, 4'b0000);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 2'd3, 4'(i), 4'b1111);
    cyc(1'b0, 2'd0, 4'h0, 4'b1111);

    // Fill everything, then reset mid-flight.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 2'(i), 4'(i + 3), 4'b0000);
    rst = 1'b1;
    cyc(1'b1, 2'd0, 4'hF, 4'b1111);
    rst = 1'b0;

    // 257 beats into channel 1: counter wraps.
    for (int i = 0; i < 257; i++)
      cyc(1'b1, 2'd1, 4'(i), 4'b1111);
    cyc(1'b0, 2'd0, 4'h0, 4'b1111);
    chk("wrap_cnt1", {24'd0, bus.beat_cnt1},
        32'd1);
    chk("wrap_cnt0", {24'd0, bus.beat_cnt0},
        32'd0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)),
          W'($urandom),
          4'($urandom));
    end
    cyc(1'b0, 2'd0, 4'h0, 4'b1111);
    cyc(1'b0, 2'd0, 4'h0, 4'b1111);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
